// File: rtl/ras_bram_ctrl.sv
// Return-address stack: TOS in a register, deeper entries spilled to a dual-port BRAM.
// Define RAS_OVERFLOW_WRAP_EN to let pushes at full overwrite the oldest spilled entry.
module ras_bram_ctrl #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 36,
    parameter int ADDR  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_valid,
    output logic             pop_ready,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             mem_ena,
    output logic             mem_wea,
    output logic [ADDR-1:0]  mem_addra,
    output logic [WIDTH-1:0] mem_dia,
    output logic             mem_enb,
    output logic             mem_web,
    output logic [WIDTH-1:0] mem_dib,
    output logic [ADDR-1:0]  mem_addrb,
    input  logic [WIDTH-1:0] mem_dob
);

    typedef enum logic {
        IDLE,
        REFILL
    } state_e;

    localparam logic [ADDR:0]   CAP    = (ADDR+1)'(DEPTH + 1);
    localparam logic [ADDR:0]   ONE    = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] SP_ONE = ADDR'(1);

    state_e           state_q, state_d;
    logic [ADDR:0]    count_q, count_d;
    logic [ADDR-1:0]  sp_q, sp_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic             ovf_q, ovf_d;

    logic idle, push_acc, pop_acc;
    logic do_refill, do_both, do_push_first, do_push_spill;
    logic do_pop_last, do_pop_fill;

    assign idle  = (state_q == IDLE);
    assign empty = (count_q == '0);
    assign full  = (count_q == CAP);

`ifdef RAS_OVERFLOW_WRAP_EN
    assign push_ready = idle;
`else
    assign push_ready = idle && !full;
`endif
    assign pop_ready  = idle && !empty;

    assign push_acc = push_valid && push_ready;
    assign pop_acc  = pop_valid && pop_ready;

    // Mutually exclusive operation selects for the decoder below
    assign do_refill     = !idle;
    assign do_both       = push_acc && pop_acc;
    assign do_push_first = push_acc && !pop_acc && empty;
    assign do_push_spill = push_acc && !pop_acc && !empty;
    assign do_pop_last   = pop_acc && !push_acc && (count_q == ONE);
    assign do_pop_fill   = pop_acc && !push_acc && (count_q != ONE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sp_d    = sp_q;
        tos_d   = tos_q;
        ovf_d   = ovf_q;
        mem_ena = 1'b0;
        mem_enb = 1'b0;
        unique case (1'b1)
            do_refill: begin
                tos_d   = mem_dob;
                state_d = IDLE;
            end
            do_both: begin
                tos_d = push_data;
            end
            do_push_first: begin
                tos_d   = push_data;
                count_d = ONE;
            end
            do_push_spill: begin
                mem_ena = 1'b1;
                tos_d   = push_data;
                sp_d    = sp_q + SP_ONE;
`ifdef RAS_OVERFLOW_WRAP_EN
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
`else
                count_d = count_q + ONE;
`endif
            end
            do_pop_last: begin
                count_d = '0;
            end
            do_pop_fill: begin
                mem_enb = 1'b1;
                sp_d    = sp_q - SP_ONE;
                count_d = count_q - ONE;
                state_d = REFILL;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            sp_q    <= '0;
            tos_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sp_q    <= sp_d;
            tos_q   <= tos_d;
            ovf_q   <= ovf_d;
        end
    end

    assign top       = tos_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign mem_wea   = mem_ena;
    assign mem_addra = sp_q;
    assign mem_dia   = tos_q;
    assign mem_addrb = sp_q - SP_ONE;
    assign mem_web   = 1'b0;
    assign mem_dib   = '0;

endmodule
